// File: rtl/grf_scoreboard_pkg.sv
// Shared types and constants for the register-file hazard scoreboard.
// The decoder uses the Tuse/Tnew classes; the scoreboard uses the rest.
package grf_scoreboard_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned TNEW_W   = 2;
   localparam int unsigned FWD_W    = 2;
   localparam int unsigned MD_CNT_W = 4;

   localparam int unsigned MULT_CYC_DEFAULT = 5;
   localparam int unsigned DIV_CYC_DEFAULT  = 10;

   localparam logic [FWD_W-1:0] FWD_GRF = 2'd0;
   localparam logic [FWD_W-1:0] FWD_E   = 2'd1;
   localparam logic [FWD_W-1:0] FWD_M   = 2'd2;

   // Operand consumption point, counted in cycles from D
   localparam logic [1:0] TUSE_D = 2'd0;
   localparam logic [1:0] TUSE_E = 2'd1;
   localparam logic [1:0] TUSE_M = 2'd2;

   // Result availability, counted in cycles after entering E
   localparam logic [TNEW_W-1:0] TNEW_LINK = 2'd0;
   localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
   localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  wa;
      logic [TNEW_W-1:0] tnew;
   } rec_t;

   // Advance a record one stage: remaining latency counts down to zero
   function automatic rec_t age_rec(input rec_t r);
      rec_t a;
      a = r;
      if (a.tnew != '0) a.tnew = a.tnew - TNEW_W'(1);
      return a;
   endfunction

endpackage

// File: rtl/grf_scoreboard_md_busy_counter.sv
// Multiply/divide busy counter: loads the operation latency on issue and
// counts down to idle; reset aborts a running operation.
module md_busy_counter
   import grf_scoreboard_pkg::*;
#(
   parameter int unsigned MULT_CYC = MULT_CYC_DEFAULT,
   parameter int unsigned DIV_CYC  = DIV_CYC_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic is_div,
   output logic busy_c
);

   logic [MD_CNT_W-1:0] md_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt <= '0;
      end else if (load) begin
         md_cnt <= is_div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - MD_CNT_W'(1);
      end
   end

   assign busy_c = (md_cnt != '0);

endmodule

// File: rtl/grf_scoreboard.sv
// Hazard scoreboard for the GRF: tracks in-flight writes in E and M and
// decides stall / operand forwarding for the instruction in D.
module grf_scoreboard
   import grf_scoreboard_pkg::*;
#(
   parameter int unsigned MULT_CYC = MULT_CYC_DEFAULT,
   parameter int unsigned DIV_CYC  = DIV_CYC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [REG_W-1:0]  D_RA1,
   input  logic [REG_W-1:0]  D_RA2,
   input  logic              D_use1,
   input  logic              D_use2,
   input  logic [1:0]        D_Tuse1,
   input  logic [1:0]        D_Tuse2,
   input  logic [REG_W-1:0]  D_WA,
   input  logic              D_RegWrite,
   input  logic [TNEW_W-1:0] D_Tnew,
   input  logic              D_isMD,
   input  logic              D_isDiv,
   input  logic              D_isHiLo,
   output logic              Stall,
   output logic [FWD_W-1:0]  D_Fwd1,
   output logic [FWD_W-1:0]  D_Fwd2,
   output logic              MD_busy
);

   // W needs no record: the register file's write-through bypass covers it.
   rec_t e_rec;
   rec_t m_rec;
   rec_t d_rec;
   logic data_stall;
   logic md_stall;
   logic md_busy_c;

   function automatic logic hit(input rec_t r, input logic use_op,
                                input logic [REG_W-1:0] ra);
      return use_op && r.valid && (r.wa == ra);
   endfunction

   function automatic logic [FWD_W-1:0] fwd_sel(input rec_t e, input rec_t m,
                                                input logic use_op,
                                                input logic [REG_W-1:0] ra);
      logic [FWD_W-1:0] sel;
      sel = FWD_GRF;
      if (hit(e, use_op, ra) && e.tnew == '0) sel = FWD_E;
      else if (hit(m, use_op, ra) && m.tnew == '0) sel = FWD_M;
      return sel;
   endfunction

   always_comb begin
      d_rec.valid = D_RegWrite && (D_WA != '0);
      d_rec.wa    = D_WA;
      d_rec.tnew  = D_Tnew;

      data_stall = (hit(e_rec, D_use1, D_RA1) && (e_rec.tnew > D_Tuse1))
                || (hit(m_rec, D_use1, D_RA1) && (m_rec.tnew > D_Tuse1))
                || (hit(e_rec, D_use2, D_RA2) && (e_rec.tnew > D_Tuse2))
                || (hit(m_rec, D_use2, D_RA2) && (m_rec.tnew > D_Tuse2));
      md_stall   = (D_isMD || D_isHiLo) && md_busy_c;

      Stall   = data_stall || md_stall;
      D_Fwd1  = fwd_sel(e_rec, m_rec, D_use1, D_RA1);
      D_Fwd2  = fwd_sel(e_rec, m_rec, D_use2, D_RA2);
      MD_busy = md_busy_c;
   end

   // Flush beats a same-edge D record; a stall inserts a bubble into E
   always_ff @(posedge clk) begin
      if (reset) begin
         e_rec <= '0;
         m_rec <= '0;
      end else begin
         m_rec <= flush ? '0 : age_rec(e_rec);
         e_rec <= (flush || Stall) ? '0 : d_rec;
      end
   end

   md_busy_counter #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_busy_counter (
      .clk    (clk),
      .reset  (reset),
      .load   (D_isMD && !Stall),
      .is_div (D_isDiv),
      .busy_c (md_busy_c)
   );

endmodule
